// File: rtl/pe_cube_pkg.sv
// Shared pe_cube sizing helpers, lane width and writeback FSM state type.
// Used by the result writeback controller and its snapshot FIFO.
// Pure declarations: no logic, no latency, no flow control.
package pe_cube_pkg;

  // Width of one pe_cube result lane.
  localparam int LANE_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } wb_state_t;

  // Number of result lanes presented by one cube array.
  function automatic int lanes_f(input int array_num, input int block_num, input int cube_num);
    return array_num * block_num * cube_num;
  endfunction

  // Number of 32-bit RAM words needed to hold one snapshot (4 lanes per word).
  function automatic int words_f(input int array_num, input int block_num, input int cube_num);
    return (lanes_f(array_num, block_num, cube_num) + 3) / 4;
  endfunction

endpackage

// File: rtl/result_snapshot_fifo.sv
// Two-entry snapshot FIFO holding whole pe_cube result vectors in arrival order.
// Latency: a push is visible at the head the cycle after it is accepted.
// Backpressure: push is ignored when full unless a pop frees a slot in the same cycle.
module result_snapshot_fifo #(
  parameter int WIDTH = 216
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr;
  logic             do_push, do_pop;

  // Pointer/count bookkeeping; a full FIFO may accept a push into the slot popped this cycle.
  always_comb begin
    do_pop   = pop_i && (count_q != 2'd0);
    do_push  = push_i && ((count_q != 2'd2) || do_pop);
    // rd_ptr + count (mod 2): the tail slot, which is the freed head slot when full.
    wr_ptr   = rd_ptr_q ^ count_q[0];
    count_d  = count_q + {1'b0, do_push} - {1'b0, do_pop};
    rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
    if (clr_i) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
    end
  end

  // Occupancy state with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Snapshot storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      slot_q[wr_ptr] <= push_dat_i;
    end
  end

  assign head_dat_o = slot_q[rd_ptr_q];
  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign count_o    = count_q;

endmodule

// File: rtl/result_writeback_ctrl.sv
// Captures pe_cube result snapshots and writes them to the output RAM as packed 32-bit words.
// Latency: first word one cycle after capture into an idle, empty controller; WORDS words back to back.
// Backpressure: none toward the array; a capture with both slots held is dropped and flagged sticky.
module result_writeback_ctrl
  import pe_cube_pkg::*;
#(
  parameter int ARRAY_NUM = 3,
  parameter int BLOCK_NUM = 3,
  parameter int CUBE_NUM  = 3,
  parameter int RAM_DEPTH = 2048,
  parameter int BASE_ADDR = 0,
  localparam int LANES = lanes_f(ARRAY_NUM, BLOCK_NUM, CUBE_NUM),
  localparam int WORDS = words_f(ARRAY_NUM, BLOCK_NUM, CUBE_NUM),
  localparam int AW    = $clog2(RAM_DEPTH)
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic                    iStart,
  input  logic [LANE_W*LANES-1:0] iResult,
  input  logic [LANES-1:0]        iResultValid,
  output logic                    oWriteEn,
  output logic [AW-1:0]           oAddr,
  output logic [31:0]             oData,
  output logic                    oBusy,
  output logic                    oOverflow
);

  localparam int              IW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int              SNAP_W   = LANE_W * LANES;
  localparam logic [IW-1:0]   LAST_IDX = IW'(WORDS - 1);
  localparam logic [AW-1:0]   BASE     = AW'(BASE_ADDR);
  localparam logic [AW-1:0]   TOP      = AW'(RAM_DEPTH - 1);

  wb_state_t           state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;

  logic [SNAP_W-1:0]   snap_dat;
  logic                capture;
  logic                push, pop, last_word;
  logic [1:0]          cnt_next;
  logic [SNAP_W-1:0]   head_dat;
  logic                fifo_full, fifo_empty;
  logic [1:0]          fifo_cnt;
  logic [WORDS*32-1:0] padded;
  logic [31:0]         word_sel;

  assign capture = |iResultValid;

  // Lanes without a valid bit are stored as zero.
  always_comb begin
    snap_dat = '0;
    for (int i = 0; i < LANES; i++) begin
      if (iResultValid[i]) begin
        snap_dat[i*LANE_W +: LANE_W] = iResult[i*LANE_W +: LANE_W];
      end
    end
  end

  result_snapshot_fifo #(
    .WIDTH (SNAP_W)
  ) u_snap_fifo (
    .clk_i      (iClk),
    .rst_i      (iRst),
    .clr_i      (iStart),
    .push_i     (push),
    .push_dat_i (snap_dat),
    .pop_i      (pop),
    .head_dat_o (head_dat),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_cnt)
  );

  // Drain sequencing, slot accounting, address advance and overflow detection.
  always_comb begin
    last_word = (state_q == DRAIN) && (idx_q == LAST_IDX);
    pop       = last_word && !iStart;
    // A slot freed by the final word of the head snapshot is reusable in the same cycle.
    push      = capture && !iStart && (!fifo_full || pop);
    cnt_next  = fifo_cnt + {1'b0, push} - {1'b0, pop};
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    ovf_d     = ovf_q;
    if (iStart) begin
      state_d = IDLE;
      idx_d   = '0;
      addr_d  = BASE;
      ovf_d   = 1'b0;
    end else begin
      if (capture && fifo_full && !pop) begin
        ovf_d = 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (push || !fifo_empty) begin
            state_d = DRAIN;
            idx_d   = '0;
          end
        end
        DRAIN: begin
          addr_d = (addr_q == TOP) ? '0 : addr_q + AW'(1);
          if (last_word) begin
            idx_d   = '0;
            state_d = (cnt_next != 2'd0) ? DRAIN : IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = ((cnt_next != 2'd0) && !iStart) || (state_d == DRAIN);
  end

  // Controller state registers with asynchronous reset.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= BASE;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  // Pack the head snapshot into 4-lane words; lanes beyond LANES read as zero.
  always_comb begin
    padded               = '0;
    padded[SNAP_W-1:0]   = head_dat;
    word_sel             = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_q == IW'(k)) begin
        word_sel = padded[k*32 +: 32];
      end
    end
  end

  assign oWriteEn  = (state_q == DRAIN);
  assign oData     = (state_q == DRAIN) ? word_sel : 32'h0;
  assign oAddr     = addr_q;
  assign oBusy     = busy_q;
  assign oOverflow = ovf_q;

endmodule
